// File: rtl/fifo_ram.sv
// Byte storage for the UART transmit queue.
// Synchronous write, asynchronous read; no reset so it maps to LUT RAM.
module fifo_ram #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [7:0]            wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [7:0]            rdata
);

    logic [7:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_txq.sv
// Transmit byte queue feeding uart_tx, with CTS gating,
// flush and a sticky overflow flag.
module uart_txq #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          wr_byte_i,
    input  logic                wr_en_i,
    input  logic                flush_i,
    input  logic                cts_en_i,
    input  logic                cts_i,
    output logic [7:0]          tx_byte_o,
    output logic                tx_en_o,
    input  logic                tx_ready_i,
    output logic                full_o,
    output logic                empty_o,
    output logic [DEPTH_LOG2:0] level_o,
    output logic                ovf_o,
    input  logic                ovf_clr_i
);

    localparam int AW = DEPTH_LOG2;

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        wr_ok;
    logic        ovf_set;
    logic        cts_ok;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level_o = wr_ptr - rd_ptr;

    assign cts_ok  = cts_i | ~cts_en_i;
    assign tx_en_o = ~empty_o & tx_ready_i & cts_ok & ~flush_i;

    // Fullness is judged before any same-cycle pop, so a write
    // racing a pop on a full queue is still dropped.
    assign wr_ok   = wr_en_i & ~full_o & ~flush_i;
    assign ovf_set = wr_en_i & full_o & ~flush_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (tx_en_o) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // A new overflow takes priority over a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_o <= 1'b0;
        end else if (ovf_set) begin
            ovf_o <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_o <= 1'b0;
        end
    end

    fifo_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk  (clk),
        .we   (wr_ok),
        .waddr(wr_ptr[AW-1:0]),
        .wdata(wr_byte_i),
        .raddr(rd_ptr[AW-1:0]),
        .rdata(tx_byte_o)
    );

endmodule

// File: tb/tb_uart_txq.sv
// Scoreboard bench for uart_txq: writes push expected bytes,
// a negedge monitor pops and compares on every tx_en_o pulse.
module tb_uart_txq;

    localparam int DL2 = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   wr_byte_i = '0;
    logic         wr_en_i = 1'b0;
    logic         flush_i = 1'b0;
    logic         cts_en_i = 1'b0;
    logic         cts_i = 1'b0;
    logic [7:0]   tx_byte_o;
    logic         tx_en_o;
    logic         tx_ready_i = 1'b0;
    logic         full_o;
    logic         empty_o;
    logic [DL2:0] level_o;
    logic         ovf_o;
    logic         ovf_clr_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_txq #(.DEPTH_LOG2(DL2)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_byte_i (wr_byte_i),
        .wr_en_i   (wr_en_i),
        .flush_i   (flush_i),
        .cts_en_i  (cts_en_i),
        .cts_i     (cts_i),
        .tx_byte_o (tx_byte_o),
        .tx_en_o   (tx_en_o),
        .tx_ready_i(tx_ready_i),
        .full_o    (full_o),
        .empty_o   (empty_o),
        .level_o   (level_o),
        .ovf_o     (ovf_o),
        .ovf_clr_i (ovf_clr_i)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every dequeue pulse must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset && tx_en_o) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got byte %0h expected no pulse",
                         tx_byte_o);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_byte_o !== e) begin
                    errors++;
                    $display("FAIL pop_byte: got %0h expected %0h",
                             tx_byte_o, e);
                end
            end
            chk("pop_ready", int'(tx_ready_i), 1);
        end
    end

    task automatic wr(input logic [7:0] b, input bit expect_ok);
        wr_byte_i = b;
        wr_en_i   = 1'b1;
        if (expect_ok) exp_q.push_back(b);
        @(posedge clk); #1;
        wr_en_i   = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic clr_ovf();
        ovf_clr_i = 1'b1;
        @(posedge clk); #1;
        ovf_clr_i = 1'b0;
    endtask

    initial begin
        int p0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", int'(empty_o), 1);
        chk("rst_full",  int'(full_o), 0);
        chk("rst_level", int'(level_o), 0);
        chk("rst_ovf",   int'(ovf_o), 0);
        chk("rst_txen",  int'(tx_en_o), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Back-to-back writes with the transmitter always ready.
        tx_ready_i = 1'b1;
        wr(8'h55, 1);
        wr(8'hA3, 1);
        wr(8'h0F, 1);
        drain(20);
        @(posedge clk); #1;
        chk("b2b_empty", int'(empty_o), 1);

        // Fill to full, overflow on the 17th write (clear same cycle loses).
        tx_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) wr(8'(i), 1);
        chk("fill_full",  int'(full_o), 1);
        chk("fill_level", int'(level_o), 16);
        chk("fill_ovf0",  int'(ovf_o), 0);
        ovf_clr_i = 1'b1;
        wr(8'h10, 0);
        ovf_clr_i = 1'b0;
        chk("ovf_set",    int'(ovf_o), 1);
        chk("ovf_level",  int'(level_o), 16);
        tx_ready_i = 1'b1;
        drain(40);
        clr_ovf();
        chk("ovf_clr",    int'(ovf_o), 0);

        // Write to a full queue while popping: dropped.
        tx_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) wr(8'(8'h20 + i), 1);
        tx_ready_i = 1'b1;
        wr(8'h77, 0);
        chk("fullpop_level", int'(level_o), 15);
        chk("fullpop_ovf",   int'(ovf_o), 1);
        drain(40);

        // Write and pop together keep the level.
        tx_ready_i = 1'b0;
        wr(8'h31, 1);
        wr(8'h32, 1);
        wr(8'h33, 1);
        chk("wp_level3", int'(level_o), 3);
        tx_ready_i = 1'b1;
        wr(8'h99, 1);
        chk("wp_level", int'(level_o), 3);
        drain(20);

        // CTS blocks pops but not writes.
        cts_en_i = 1'b1;
        cts_i    = 1'b0;
        wr(8'h41, 1);
        wr(8'h42, 1);
        p0 = pulses;
        repeat (1000) @(posedge clk);
        #1;
        chk("cts_nopulse", pulses - p0, 0);
        chk("cts_level",   int'(level_o), 2);
        cts_i = 1'b1;
        #1;
        chk("cts_txen", int'(tx_en_o), 1);
        chk("cts_byte", int'(tx_byte_o), 8'h41);
        drain(20);
        cts_en_i = 1'b0;
        cts_i    = 1'b0;

        // Flush together with a write; ovf is still set from before.
        tx_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) wr(8'(8'h50 + i), 0);
        chk("fl_level5", int'(level_o), 5);
        flush_i = 1'b1;
        wr(8'hEE, 0);
        flush_i = 1'b0;
        chk("fl_level", int'(level_o), 0);
        chk("fl_empty", int'(empty_o), 1);
        chk("fl_ovf",   int'(ovf_o), 1);

        // Asynchronous reset with bytes queued mid-frame.
        wr(8'hA1, 0);
        wr(8'hA2, 0);
        #2 reset = 1'b1;
        tx_ready_i = 1'b1;
        #1;
        chk("ar_empty", int'(empty_o), 1);
        chk("ar_level", int'(level_o), 0);
        chk("ar_ovf",   int'(ovf_o), 0);
        chk("ar_txen",  int'(tx_en_o), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        p0 = pulses;
        repeat (20) @(posedge clk);
        #1;
        chk("ar_nopulse", pulses - p0, 0);
        chk("ar_empty2",  int'(empty_o), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
